spi_reader: RTL and testbench

SPI_READER -- requirements
Module: spi_reader

---
 rtl/spi_reader_pkg.sv | 15 +
 rtl/spi_reader_if.sv | 33 +++
 rtl/spi_byte_reader.sv | 65 ++++++
 rtl/spi_reader.sv | 57 +++++
 tb/tb_spi_reader.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/spi_reader_pkg.sv
// spi_reader_pkg: shared widths and types for the SPI byte reader.
//   BYTE_W   - bits per SPI byte
//   byte_t   - one byte
//   bitcnt_t - bit-position counter within a byte
package spi_reader_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef logic [BYTE_W-1:0]         byte_t;
    typedef logic [$clog2(BYTE_W)-1:0] bitcnt_t;

    // Counter value on the edge that captures the final bit of a byte.
    localparam bitcnt_t LAST_BIT = bitcnt_t'(BYTE_W - 1);

endpackage : spi_reader_pkg

// File: rtl/spi_reader_if.sv
// spi_reader_if: SPI slave pins plus the received-byte output.
//   cs       - chip select, active-low
//   mosi     - serial data from the master, MSB first
//   miso     - serial data to the master, MSB first
//   data     - last completely received byte
//   data_clk - byte strobe; rising edge marks data valid
// Modports: master (SPI master / byte consumer side), slave (spi_reader side).
interface spi_reader_if;
    import spi_reader_pkg::*;

    logic  cs;
    logic  mosi;
    logic  miso;
    byte_t data;
    logic  data_clk;

    modport master (
        output cs,
        output mosi,
        input  miso,
        input  data,
        input  data_clk
    );

    modport slave (
        input  cs,
        input  mosi,
        output miso,
        output data,
        output data_clk
    );

endinterface : spi_reader_if

// File: rtl/spi_byte_reader.sv
// spi_byte_reader: SPI mode-0 receive path, clocked directly by the SPI clock.
//   rst_n    - asynchronous active-low reset (clears everything, data included)
//   enable   - active-low select (driven by cs); high asynchronously clears the
//              bit counter, partial byte and strobe, but keeps data
//   clk      - SPI serial clock; mosi sampled on the rising edge
//   mosi     - serial data in, MSB first
//   data_clk - high for one clk period after the bit-8 edge
//   data     - last completely received byte
module spi_byte_reader
    import spi_reader_pkg::*;
(
    input  logic  rst_n,
    input  logic  enable,
    input  logic  clk,
    input  logic  mosi,
    output logic  data_clk,
    output byte_t data
);

    // Deselect acts as a second asynchronous clear for the per-byte state.
    logic clr_n;
    assign clr_n = rst_n & ~enable;

    bitcnt_t cnt_q, cnt_d;
    // Only the first seven bits need storage; the eighth goes straight into data.
    logic [BYTE_W-2:0] shift_q, shift_d;
    byte_t             data_q, data_d;
    logic              data_clk_q, data_clk_d;
    logic              last_bit;

    always_comb begin
        last_bit   = (cnt_q == LAST_BIT);
        cnt_d      = cnt_q + bitcnt_t'(1);
        shift_d    = {shift_q[BYTE_W-3:0], mosi};
        data_clk_d = last_bit;
        data_d     = data_q;
        if (last_bit && !enable) begin
            data_d = {shift_q, mosi};
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q      <= '0;
            shift_q    <= '0;
            data_clk_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            data_clk_q <= data_clk_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_clk = data_clk_q;
    assign data     = data_q;

endmodule : spi_byte_reader

// File: rtl/spi_reader.sv
// spi_reader: SPI mode-0 slave that receives bytes on mosi and, optionally,
// echoes the previously received byte on miso.
//   clk   - SPI serial clock (the only clock)
//   rst_n - asynchronous active-low reset
//   bus   - spi_reader_if.slave: cs, mosi, miso, data, data_clk
// Build option: define SPI_READER_ECHO_EN to load the transmit register with
// the last received byte; otherwise it loads 8'h00 and miso stays 0.
module spi_reader
    import spi_reader_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    spi_reader_if.slave  bus
);

    spi_byte_reader u_byte_reader (
        .rst_n    (rst_n),
        .enable   (bus.cs),
        .clk      (clk),
        .mosi     (bus.mosi),
        .data_clk (bus.data_clk),
        .data     (bus.data)
    );

    byte_t tx_q, tx_d;
    byte_t tx_load;

`ifdef SPI_READER_ECHO_EN
    assign tx_load = bus.data;
`else
    assign tx_load = '0;
`endif

    // data_clk is high exactly between the bit-8 rising edge and the next
    // rising edge, so the falling edge it spans is the byte-boundary edge.
    always_comb begin
        tx_d = tx_q;
        if (!bus.cs) begin
            if (bus.data_clk) begin
                tx_d = tx_load;
            end else begin
                tx_d = {tx_q[BYTE_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q <= '0;
        end else begin
            tx_q <= tx_d;
        end
    end

    assign bus.miso = tx_q[BYTE_W-1] & ~bus.cs;

endmodule : spi_reader

// File: tb/tb_spi_reader.sv
// tb_spi_reader: self-checking bench for spi_reader. Expected bytes go into a
// scoreboard queue as they are driven and are popped on each data_clk strobe.
module tb_spi_reader;
    import spi_reader_pkg::*;

`ifdef SPI_READER_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    logic clk;
    logic rst_n;

    spi_reader_if bus ();

    spi_reader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int    n_checks  = 0;
    int    n_errors  = 0;
    int    n_strobes = 0;
    byte_t exp_q[$];
    byte_t miso_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive the top nbits of val MSB first; miso is sampled just before each
    // rising edge, as a mode-0 master would.
    task automatic send_bits(input byte_t val, input int nbits);
        miso_seen = '0;
        for (int i = 0; i < nbits; i++) begin
            bus.mosi = val[BYTE_W-1-i];
            #4;
            miso_seen = {miso_seen[BYTE_W-2:0], bus.miso};
            #1;
            clk = 1'b1;
            #5;
            clk = 1'b0;
        end
    endtask

    task automatic send_byte(input byte_t val, input byte_t exp_miso, input bit chk_miso,
                             input string tag);
        exp_q.push_back(val);
        send_bits(val, BYTE_W);
        if (chk_miso) check({tag, "_miso"}, 32'(miso_seen), 32'(exp_miso));
    endtask

    // Scoreboard consumer.
    always @(posedge bus.data_clk) begin
        #1;
        n_strobes++;
        check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            check("sb_data", 32'(bus.data), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        clk      = 1'b0;
        rst_n    = 1'b1;
        bus.cs   = 1'b1;
        bus.mosi = 1'b0;

        // Reset state.
        #2 rst_n = 1'b0;
        #3;
        check("rst_data", 32'(bus.data), 32'h00);
        check("rst_data_clk", 32'(bus.data_clk), 32'd0);
        check("rst_miso", 32'(bus.miso), 32'd0);
        #5 rst_n = 1'b1;
        #5;

        // Back-to-back 'E', 'i'.
        bus.cs = 1'b0;
        #5;
        send_byte(8'h45, 8'h00, 1'b1, "b45");
        send_byte(8'h69, ECHO ? 8'h45 : 8'h00, 1'b1, "b69");
        check("strobe_cnt_2", 32'(n_strobes), 32'd2);
        #20;
        check("strobe_held_clk_stopped", 32'(bus.data_clk), 32'd1);
        check("data_69", 32'(bus.data), 32'h69);

        // Stop clk high, deselect for three periods, resume with 'k'.
        bus.mosi = 1'b0;
        clk = 1'b1;
        #1;
        check("strobe_one_period", 32'(bus.data_clk), 32'd0);
        #4 bus.cs = 1'b1;
        #30 clk = 1'b0;
        #5 bus.cs = 1'b0;
        #5;
        send_byte(8'h6B, ECHO ? 8'h69 : 8'h00, 1'b1, "b6b");
        check("strobe_cnt_3", 32'(n_strobes), 32'd3);

        // Deselect clears the strobe immediately, data retained, miso low.
        bus.cs = 1'b1;
        #1;
        check("cs_clears_strobe", 32'(bus.data_clk), 32'd0);
        check("cs_keeps_data", 32'(bus.data), 32'h6B);
        check("cs_miso_low", 32'(bus.miso), 32'd0);

        // Clock toggling while deselected is ignored.
        bus.mosi = 1'b1;
        repeat (4) begin
            #5 clk = 1'b1;
            #5 clk = 1'b0;
        end
        check("cs_hi_no_strobe", 32'(n_strobes), 32'd3);
        bus.cs = 1'b0;
        #5;
        send_byte(8'hB3, ECHO ? 8'h6B : 8'h00, 1'b1, "bb3");
        check("strobe_cnt_4", 32'(n_strobes), 32'd4);

        // Partial byte aborted by cs.
        bus.cs = 1'b1;
        #10 bus.cs = 1'b0;
        #5;
        send_bits(8'hFF, 5);
        bus.cs = 1'b1;
        #5;
        check("abort_keeps_data", 32'(bus.data), 32'hB3);
        check("abort_no_strobe", 32'(n_strobes), 32'd4);
        bus.cs = 1'b0;
        #5;
        send_byte(8'hA5, 8'h00, 1'b0, "ba5");
        check("strobe_cnt_5", 32'(n_strobes), 32'd5);

        // Clock paused mid-byte with cs low keeps the partial byte.
        exp_q.push_back(8'hC7);
        send_bits(8'hC7, 4);
        #50;
        check("pause_no_strobe", 32'(bus.data_clk), 32'd0);
        check("pause_keeps_data", 32'(bus.data), 32'hA5);
        send_bits(8'h70, 4);
        check("strobe_cnt_6", 32'(n_strobes), 32'd6);

        // Reset mid-byte.
        send_bits(8'hE0, 3);
        rst_n = 1'b0;
        #1;
        check("midrst_data", 32'(bus.data), 32'h00);
        check("midrst_data_clk", 32'(bus.data_clk), 32'd0);
        check("midrst_miso", 32'(bus.miso), 32'd0);
        #5 rst_n = 1'b1;
        #5;
        send_byte(8'h3C, 8'h00, 1'b1, "b3c");
        #20;
        check("data_3c", 32'(bus.data), 32'h3C);
        check("strobe_cnt_7", 32'(n_strobes), 32'd7);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_spi_reader
